// File: rtl/axi_wr_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_wr_slave_pkg
// Shared definitions for the ddr2_ctrl write-channel front end: DDR2 geometry
// (row/column/bank address bits, DQ width) and the write-responder FSM states.
// No ports.
// -----------------------------------------------------------------------------
package axi_wr_slave_pkg;

    localparam int ROW_BITS = 13;
    localparam int COL_BITS = 10;
    localparam int BA_BITS  = 3;
    localparam int DQ_BITS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BURST     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } wr_state_t;

endpackage

// File: rtl/axi_wr_slave_sync_fifo.sv
// -----------------------------------------------------------------------------
// axi_wr_slave_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on head while empty is low. A beat pushed at edge N is visible after edge N.
// Pushes while full and pops while empty are ignored.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset (flushes the FIFO)
//   push       write push_data this cycle
//   push_data  data to store
//   pop        advance the read pointer this cycle
//   head       oldest stored entry (FWFT)
//   full       no free entry
//   empty      no stored entry
// -----------------------------------------------------------------------------
module axi_wr_slave_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);

    // One extra pointer bit distinguishes full from empty when the index bits match.
    logic [PTR_BITS:0]     wr_ptr;
    logic [PTR_BITS:0]     rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define
    // which entries are valid, and leaving it reset-free lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_BITS-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[PTR_BITS-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                   (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);

endmodule

// File: rtl/axi_wr_slave.sv
// -----------------------------------------------------------------------------
// axi_wr_slave
// AXI-style write-channel responder in front of the ddr2_ctrl scheduler.
// Accepts one AW transaction at a time, buffers its W beats in a FWFT FIFO,
// issues one burst command to the scheduler, and returns B once the scheduler
// reports the burst written.
//
// Ports:
//   clk, rst                  controller clock, async active-high reset
//   init_end                  DDR2 init complete; gates awready in IDLE
//   awvalid/awready/awaddr/awlen   write address channel (awlen = beats-1)
//   wvalid/wready/wlast/wdata      write data channel
//   bvalid/bready             write response channel
//   cmd_valid/cmd_ready/cmd_addr/cmd_len   burst command to the scheduler
//   wr_data/wr_empty/wr_rd    FIFO head, empty flag and pop from the scheduler
//   wr_done                   pulse: scheduler finished the current burst
//   len_err                   pulse: wlast position disagreed with awlen
// -----------------------------------------------------------------------------
module axi_wr_slave
    import axi_wr_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = ROW_BITS + COL_BITS + BA_BITS,
    parameter int DATA_WIDTH = DQ_BITS * 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_end,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  wlast,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_empty,
    input  logic                  wr_rd,
    input  logic                  wr_done,
    output logic                  len_err
);

    wr_state_t            state;
    wr_state_t            next_state;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic                 data_done;    // last beat of the burst accepted
    logic                 cmd_done;     // burst command accepted by scheduler
    logic                 done_sticky;  // wr_done seen while still in BURST
    logic                 out_en;       // low from reset until the first edge after release
    logic                 fifo_full;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 cmd_hs;
    logic                 b_hs;
    logic                 cnt_match;
    logic                 beat_last;
    logic                 burst_complete;

    // out_en keeps awready low while rst is held even if init_end is already high.
    assign awready = (state == ST_IDLE) && init_end && out_en;
    assign wready  = (state == ST_BURST) && !data_done && !fifo_full;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign cmd_hs = cmd_valid && cmd_ready;
    assign b_hs   = bvalid && bready;

    // A beat is last on wlast or on reaching the latched length, whichever is first.
    assign cnt_match      = (beat_cnt == CNT_WIDTH'(cmd_len));
    assign beat_last      = w_hs && (wlast || cnt_match);
    assign burst_complete = (cmd_done || cmd_hs) && (data_done || beat_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state is assigned a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:      if (aw_hs)                   next_state = ST_BURST;
            ST_BURST:     if (burst_complete)          next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: if (wr_done || done_sticky)  next_state = ST_RESP;
            ST_RESP:      if (b_hs)                    next_state = ST_IDLE;
            default:                                   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid   <= 1'b0;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            beat_cnt    <= '0;
            data_done   <= 1'b0;
            cmd_done    <= 1'b0;
            done_sticky <= 1'b0;
            bvalid      <= 1'b0;
            len_err     <= 1'b0;
            out_en      <= 1'b0;
        end else begin
            out_en  <= 1'b1;
            len_err <= w_hs && (wlast != cnt_match);

            if (aw_hs) begin
                cmd_addr    <= awaddr;
                cmd_len     <= awlen;
                cmd_valid   <= 1'b1;
                beat_cnt    <= '0;
                data_done   <= 1'b0;
                cmd_done    <= 1'b0;
                done_sticky <= 1'b0;
            end

            if (cmd_hs) begin
                cmd_valid <= 1'b0;
                cmd_done  <= 1'b1;
            end

            if (w_hs) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (wlast || cnt_match) data_done <= 1'b1;
            end

            // The scheduler may finish before the last beat is accepted here.
            if ((state == ST_BURST) && wr_done) done_sticky <= 1'b1;

            if ((state == ST_WAIT_DONE) && (next_state == ST_RESP)) begin
                bvalid      <= 1'b1;
                done_sticky <= 1'b0;
            end

            if (b_hs) bvalid <= 1'b0;
        end
    end

    axi_wr_slave_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_hs),
        .push_data (wdata),
        .pop       (wr_rd),
        .head      (wr_data),
        .full      (fifo_full),
        .empty     (wr_empty)
    );

endmodule

// File: tb/tb_axi_wr_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_slave
// Directed bench for axi_wr_slave: AW gating by init_end, normal bursts,
// FIFO back-pressure, wlast/awlen disagreement, early wr_done, mid-burst reset.
// -----------------------------------------------------------------------------
module tb_axi_wr_slave;
    import axi_wr_slave_pkg::*;

    localparam int AW = ROW_BITS + COL_BITS + BA_BITS;
    localparam int DW = DQ_BITS * 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_end;
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid;
    logic          wready;
    logic          wlast;
    logic [DW-1:0] wdata;
    logic          bvalid;
    logic          bready;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_empty;
    logic          wr_rd;
    logic          wr_done;
    logic          len_err;

    axi_wr_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (16),
        .CNT_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_end  (init_end),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .wvalid    (wvalid),
        .wready    (wready),
        .wlast     (wlast),
        .wdata     (wdata),
        .bvalid    (bvalid),
        .bready    (bready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_empty  (wr_empty),
        .wr_rd     (wr_rd),
        .wr_done   (wr_done),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stream state: master sends beat_base+i, wlast on index wlast_idx;
    // scheduler pops when pop_en and raises cmd_ready cmd_delay cycles late.
    int   acc_cnt;
    int   pop_cnt;
    int   n_send;
    int   wlast_idx;
    int   cmd_delay;
    int   cmd_wait;
    int   len_err_cnt;
    int   beat_base;
    logic pop_en;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stream(input int base, input int nsend, input int last_idx,
                              input logic pop, input int cdelay);
        beat_base   = base;
        n_send      = nsend;
        wlast_idx   = last_idx;
        pop_en      = pop;
        cmd_delay   = cdelay;
        cmd_wait    = 0;
        acc_cnt     = 0;
        pop_cnt     = 0;
        len_err_cnt = 0;
    endtask

    // One clock of master + scheduler behaviour; checks every popped word.
    task automatic step();
        logic w_acc;
        logic p_acc;
        wvalid    = (acc_cnt < n_send);
        wdata     = DW'(beat_base + acc_cnt);
        wlast     = (acc_cnt == wlast_idx);
        wr_rd     = pop_en;
        cmd_ready = cmd_valid && (cmd_wait >= cmd_delay);
        #1;
        w_acc = wvalid && wready;
        p_acc = wr_rd && !wr_empty;
        if (p_acc) check("pop_data", 64'(wr_data), 64'(beat_base + pop_cnt));
        if (len_err) len_err_cnt++;
        if (cmd_valid && !cmd_ready) cmd_wait++;
        tick();
        if (w_acc) acc_cnt++;
        if (p_acc) pop_cnt++;
    endtask

    task automatic start_burst(input int addr, input int len, input int base, input int nsend,
                               input int last_idx, input logic pop, input int cdelay);
        set_stream(base, nsend, last_idx, pop, cdelay);
        awaddr  = AW'(addr);
        awlen   = 8'(len);
        awvalid = 1'b1;
        for (int i = 0; i < 10 && !awready; i++) tick();
        check("aw_ready", 64'(awready), 64'(1));
        tick();
        awvalid = 1'b0;
        check("cmd_addr", 64'(cmd_addr), 64'(addr));
        check("cmd_len", 64'(cmd_len), 64'(len));
    endtask

    task automatic finish_burst();
        wvalid    = 1'b0;
        wr_rd     = 1'b0;
        cmd_ready = 1'b0;
        wr_done   = 1'b1;
        tick();
        wr_done = 1'b0;
        check("bvalid_set", 64'(bvalid), 64'(1));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_clr", 64'(bvalid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; init_end = 1'b0; awvalid = 1'b0; awaddr = '0; awlen = '0;
        wvalid = 1'b0; wlast = 1'b0; wdata = '0; bready = 1'b0; cmd_ready = 1'b0;
        wr_rd = 1'b0; wr_done = 1'b0;
        set_stream(0, 0, -1, 1'b0, 0);
        tick(); tick();

        // Reset values
        check("rst_awready", 64'(awready), 64'(0));
        check("rst_wready", 64'(wready), 64'(0));
        check("rst_bvalid", 64'(bvalid), 64'(0));
        check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check("rst_cmd_addr", 64'(cmd_addr), 64'(0));
        check("rst_cmd_len", 64'(cmd_len), 64'(0));
        check("rst_len_err", 64'(len_err), 64'(0));
        check("rst_wr_empty", 64'(wr_empty), 64'(1));
        rst = 1'b0;

        // 1: AW blocked until init_end, then accepted the same cycle
        awvalid = 1'b1; awaddr = AW'(32'h100); awlen = 8'd7;
        tick(); tick(); tick();
        check("t1_awready_no_init", 64'(awready), 64'(0));
        check("t1_no_cmd", 64'(cmd_valid), 64'(0));
        init_end = 1'b1;
        #1;
        check("t1_awready_init", 64'(awready), 64'(1));
        tick();
        awvalid = 1'b0;
        check("t1_cmd_addr", 64'(cmd_addr), 64'(32'h100));
        check("t1_cmd_len", 64'(cmd_len), 64'(7));
        check("t1_cmd_valid", 64'(cmd_valid), 64'(1));
        check("t1_awready_busy", 64'(awready), 64'(0));

        // 2: 8 beats A0..A7, continuous pops, cmd_ready 3 cycles late
        set_stream(32'hA0, 8, 7, 1'b1, 3);
        for (int i = 0; i < 40 && !(acc_cnt == 8 && pop_cnt == 8); i++) step();
        check("t2_accepted", 64'(acc_cnt), 64'(8));
        check("t2_popped", 64'(pop_cnt), 64'(8));
        check("t2_len_err", 64'(len_err_cnt), 64'(0));
        check("t2_cmd_dropped", 64'(cmd_valid), 64'(0));
        check("t2_wr_empty", 64'(wr_empty), 64'(1));
        check("t2_wready_wait", 64'(wready), 64'(0));
        wr_rd = 1'b0; wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        check("t2_bvalid", 64'(bvalid), 64'(1));
        tick(); tick();
        check("t2_bvalid_held", 64'(bvalid), 64'(1));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("t2_bvalid_clr", 64'(bvalid), 64'(0));
        check("t2_awready_idle", 64'(awready), 64'(1));

        // 3: 32 beats into a 16-deep FIFO, no pops for 20 cycles
        start_burst(32'h200, 31, 32'h00, 32, 31, 1'b0, 0);
        for (int i = 0; i < 20; i++) step();
        check("t3_fill_count", 64'(acc_cnt), 64'(16));
        check("t3_wready_full", 64'(wready), 64'(0));
        check("t3_not_empty", 64'(wr_empty), 64'(0));
        pop_en = 1'b1;
        for (int i = 0; i < 100 && pop_cnt != 32; i++) step();
        check("t3_accepted", 64'(acc_cnt), 64'(32));
        check("t3_popped", 64'(pop_cnt), 64'(32));
        check("t3_len_err", 64'(len_err_cnt), 64'(0));
        finish_burst();

        // 4a: awlen=7 but wlast on beat 5
        start_burst(32'h300, 7, 32'h30, 8, 4, 1'b1, 0);
        for (int i = 0; i < 20; i++) step();
        check("t4a_accepted", 64'(acc_cnt), 64'(5));
        check("t4a_popped", 64'(pop_cnt), 64'(5));
        check("t4a_len_err", 64'(len_err_cnt), 64'(1));
        check("t4a_cmd_len", 64'(cmd_len), 64'(7));
        finish_burst();

        // 4b: awlen=3 and no wlast on beat 4
        start_burst(32'h400, 3, 32'h40, 6, 99, 1'b1, 0);
        for (int i = 0; i < 20; i++) step();
        check("t4b_accepted", 64'(acc_cnt), 64'(4));
        check("t4b_popped", 64'(pop_cnt), 64'(4));
        check("t4b_len_err", 64'(len_err_cnt), 64'(1));
        finish_burst();

        // 5: wr_done arrives in BURST before the last beat
        start_burst(32'h500, 3, 32'h50, 3, 3, 1'b1, 0);
        for (int i = 0; i < 6; i++) step();
        check("t5_three_beats", 64'(acc_cnt), 64'(3));
        check("t5_cmd_accepted", 64'(cmd_valid), 64'(0));
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        check("t5_still_burst", 64'(wready), 64'(1));
        check("t5_no_early_b", 64'(bvalid), 64'(0));
        n_send = 4;
        for (int i = 0; i < 10 && acc_cnt != 4; i++) step();
        check("t5_accepted", 64'(acc_cnt), 64'(4));
        wvalid = 1'b0;
        for (int i = 0; i < 4 && !bvalid; i++) tick();
        check("t5_bvalid_sticky", 64'(bvalid), 64'(1));
        bready = 1'b1;
        tick();
        bready = 1'b0; wr_rd = 1'b0;
        check("t5_bvalid_clr", 64'(bvalid), 64'(0));

        // 6: reset after 3 beats, then a fresh burst
        start_burst(32'h600, 7, 32'h60, 8, 7, 1'b0, 10);
        for (int i = 0; i < 10 && acc_cnt != 3; i++) step();
        check("t6_three_beats", 64'(acc_cnt), 64'(3));
        check("t6_cmd_pending", 64'(cmd_valid), 64'(1));
        wvalid = 1'b0; cmd_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("t6_awready", 64'(awready), 64'(0));
        check("t6_wready", 64'(wready), 64'(0));
        check("t6_wr_empty", 64'(wr_empty), 64'(1));
        check("t6_cmd_valid", 64'(cmd_valid), 64'(0));
        check("t6_bvalid", 64'(bvalid), 64'(0));
        rst = 1'b0;
        tick();
        start_burst(32'h700, 1, 32'h70, 2, 1, 1'b1, 0);
        for (int i = 0; i < 20 && pop_cnt != 2; i++) step();
        check("t6_fresh_accepted", 64'(acc_cnt), 64'(2));
        check("t6_fresh_popped", 64'(pop_cnt), 64'(2));
        check("t6_fresh_len_err", 64'(len_err_cnt), 64'(0));
        finish_burst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
